// File: rtl/seq_alu_if.sv
// Handshake and data bundle between a producer/consumer and seq_alu.
// The master drives operands and out_ready; the slave (the ALU) drives results.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             op;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     result;
    logic                   div_by_zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, div_by_zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, div_by_zero
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential unsigned ALU: add/sub and div-by-zero finish in one cycle.
// mul (shift-add) and div (restoring) are bit-serial and take WIDTH cycles.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    seq_alu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state_q;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 dbz_q;
    logic [2*WIDTH-1:0]   result_q;

    logic                 fast_d;
    logic                 dbz_d;
    logic [2*WIDTH-1:0]   fast_res_d;
    logic [2*WIDTH-1:0]   calc_init_d;
    logic [WIDTH-1:0]     opnd_d;
    logic [2*WIDTH-1:0]   acc_d;

    // acc holds {partial product high, remaining multiplier bits}; add then shift right.
    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [2*WIDTH-1:0] p,
        input logic [WIDTH-1:0]   m
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {sum, p[WIDTH-1:1]};
    endfunction

    // acc holds {remainder, dividend/quotient}; shift in next dividend bit, trial-subtract.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [2*WIDTH-1:0] rq,
        input logic [WIDTH-1:0]   d
    );
        logic [WIDTH:0]   rem_sh;
        logic [WIDTH-1:0] rem_sub;
        rem_sh  = {rq[2*WIDTH-1:WIDTH], rq[WIDTH-1]};
        rem_sub = rem_sh[WIDTH-1:0] - d;
        if (rem_sh >= {1'b0, d}) begin
            return {rem_sub, rq[WIDTH-2:0], 1'b1};
        end else begin
            return {rem_sh[WIDTH-1:0], rq[WIDTH-2:0], 1'b0};
        end
    endfunction

    // Decode an incoming bundle: single-cycle results or the initial serial accumulator.
    always_comb begin
        fast_d      = 1'b0;
        dbz_d       = 1'b0;
        fast_res_d  = {(2*WIDTH){1'b0}};
        calc_init_d = {(2*WIDTH){1'b0}};
        opnd_d      = bus.b;
        case (bus.op)
            OP_ADD: begin
                fast_d     = 1'b1;
                fast_res_d = {{(WIDTH-1){1'b0}}, {1'b0, bus.a} + {1'b0, bus.b}};
            end
            OP_SUB: begin
                fast_d     = 1'b1;
                fast_res_d = {{(WIDTH-1){1'b0}}, {1'b0, bus.a} - {1'b0, bus.b}};
            end
            OP_MUL: begin
                opnd_d      = bus.a;
                calc_init_d = {{WIDTH{1'b0}}, bus.b};
            end
            OP_DIV: begin
                if (bus.b == {WIDTH{1'b0}}) begin
                    fast_d     = 1'b1;
                    dbz_d      = 1'b1;
                    fast_res_d = {bus.a, {WIDTH{1'b1}}};
                end else begin
                    calc_init_d = {{WIDTH{1'b0}}, bus.a};
                end
            end
            default: begin
                fast_d = 1'b0;
            end
        endcase
    end

    // One serial step of whichever long operation is in flight.
    always_comb begin
        if (op_q == OP_MUL) begin
            acc_d = mul_step(acc_q, opnd_q);
        end else begin
            acc_d = div_step(acc_q, opnd_q);
        end
    end

    // Control FSM, operand capture, serial datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            opnd_q      <= {WIDTH{1'b0}};
            acc_q       <= {(2*WIDTH){1'b0}};
            cnt_q       <= {CW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            result_q    <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        op_q       <= bus.op;
                        opnd_q     <= opnd_d;
                        in_ready_q <= 1'b0;
                        if (fast_d) begin
                            state_q     <= DONE;
                            result_q    <= fast_res_d;
                            dbz_q       <= dbz_d;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            acc_q   <= calc_init_d;
                            cnt_q   <= CW'(WIDTH - 1);
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    if (cnt_q == {CW{1'b0}}) begin
                        state_q     <= DONE;
                        result_q    <= acc_d;
                        dbz_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    // result is held after completion; only the qualifier is cleared.
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        dbz_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    dbz_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=8 and WIDTH=16: directed scenarios
// plus randomized operations against an arithmetic reference model.
module tb_seq_alu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        in_valid_t;
    logic        out_ready_t;
    logic [1:0]  op_t;
    logic [15:0] a_t;
    logic [15:0] b_t;

    seq_alu_if #(.WIDTH(8))  if8();
    seq_alu_if #(.WIDTH(16)) if16();

    seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    seq_alu #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    assign if8.in_valid   = in_valid_t & ~sel;
    assign if8.out_ready  = out_ready_t & ~sel;
    assign if8.op         = op_t;
    assign if8.a          = a_t[7:0];
    assign if8.b          = b_t[7:0];
    assign if16.in_valid  = in_valid_t & sel;
    assign if16.out_ready = out_ready_t & sel;
    assign if16.op        = op_t;
    assign if16.a         = a_t;
    assign if16.b         = b_t;

    logic [31:0] res_m;
    logic        ov_m;
    logic        ir_m;
    logic        dbz_m;
    always_comb begin
        if (sel) begin
            res_m = {16'h0000, if16.result};
            ov_m  = if16.out_valid;
            ir_m  = if16.in_ready;
            dbz_m = if16.div_by_zero;
        end else begin
            res_m = {16'h0000, 16'h0000} | {16'h0000, 8'h00, 8'h00} | {16'h0000, if8.result};
            ov_m  = if8.out_valid;
            ir_m  = if8.in_ready;
            dbz_m = if8.div_by_zero;
        end
    end

    int errors = 0;
    int checks = 0;

    function automatic void model(input int w, input logic [1:0] o, input logic [31:0] x,
                                  input logic [31:0] y, output logic [31:0] r,
                                  output logic z, output int lat);
        longint unsigned xa, ya, m;
        xa = 64'(x);
        ya = 64'(y);
        m = (64'd1 << w) - 64'd1;
        z = 1'b0;
        lat = w + 1;
        case (o)
            2'b00: begin r = 32'(xa + ya); lat = 1; end
            2'b01: begin
                r = 32'(((xa - ya) & m) | ((xa < ya) ? (64'd1 << w) : 64'd0));
                lat = 1;
            end
            2'b10: r = 32'(xa * ya);
            default: begin
                if (ya == 64'd0) begin
                    r = 32'((xa << w) | m);
                    z = 1'b1;
                    lat = 1;
                end else begin
                    r = 32'(((xa % ya) << w) | (xa / ya));
                end
            end
        endcase
    endfunction

    // Present a bundle while the DUT is idle; lat = edges from accept until out_valid (-1 on timeout).
    task automatic issue(input bit s, input logic [1:0] o, input logic [15:0] x,
                         input logic [15:0] y, output int lat);
        sel = s; op_t = o; a_t = x; b_t = y; in_valid_t = 1'b1;
        @(posedge clk); #1;
        in_valid_t = 1'b0;
        a_t = 16'($urandom); b_t = 16'($urandom); op_t = 2'($urandom_range(0, 3));
        lat = 1;
        while (!ov_m && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ov_m) lat = -1;
    endtask

    task automatic consume();
        out_ready_t = 1'b1;
        @(posedge clk); #1;
        out_ready_t = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid_t = 1'b0; out_ready_t = 1'b0; sel = 1'b0;
        op_t = 2'b00; a_t = 16'd0; b_t = 16'd0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if (ir_m !== 1'b1 || ov_m !== 1'b0 || res_m !== 32'd0 || dbz_m !== 1'b0) begin
                errors++;
                $display("FAIL reset_state sel=%0d: in_ready=%b out_valid=%b result=%h dbz=%b, want 1 0 0 0",
                         s, ir_m, ov_m, res_m, dbz_m);
            end
        end
        sel = 1'b0;
        // rst must win over a simultaneous in_valid
        rst = 1'b1; in_valid_t = 1'b1; op_t = 2'b00; a_t = 16'd3; b_t = 16'd4;
        @(posedge clk); #1;
        rst = 1'b0; in_valid_t = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ov_m !== 1'b0 || ir_m !== 1'b1) begin
            errors++;
            $display("FAIL reset_dominates: out_valid=%b in_ready=%b, want 0 1", ov_m, ir_m);
        end
    endtask

    task automatic test_add();
        int lat;
        issue(1'b0, 2'b00, 16'd200, 16'd100, lat);
        checks++;
        if (lat !== 1 || res_m !== 32'h012C || dbz_m !== 1'b0) begin
            errors++;
            $display("FAIL add_200_100: lat=%0d result=%h dbz=%b, want 1 012c 0", lat, res_m, dbz_m);
        end
        consume();
        checks++;
        if (ir_m !== 1'b1 || ov_m !== 1'b0) begin
            errors++;
            $display("FAIL add_release: in_ready=%b out_valid=%b, want 1 0", ir_m, ov_m);
        end
    endtask

    task automatic test_sub_mul();
        int lat;
        issue(1'b0, 2'b01, 16'd5, 16'd10, lat);
        checks++;
        if (lat !== 1 || res_m !== 32'h01FB || dbz_m !== 1'b0) begin
            errors++;
            $display("FAIL sub_5_10: lat=%0d result=%h dbz=%b, want 1 01fb 0", lat, res_m, dbz_m);
        end
        consume();
        issue(1'b0, 2'b10, 16'd255, 16'd255, lat);
        checks++;
        if (lat !== 9 || res_m !== 32'hFE01 || dbz_m !== 1'b0) begin
            errors++;
            $display("FAIL mul_255_255: lat=%0d result=%h dbz=%b, want 9 fe01 0", lat, res_m, dbz_m);
        end
        consume();
    endtask

    task automatic test_div();
        int lat;
        issue(1'b0, 2'b11, 16'd200, 16'd7, lat);
        checks++;
        if (lat !== 9 || res_m !== 32'h041C || dbz_m !== 1'b0) begin
            errors++;
            $display("FAIL div_200_7: lat=%0d result=%h dbz=%b, want 9 041c 0", lat, res_m, dbz_m);
        end
        consume();
        issue(1'b0, 2'b11, 16'd9, 16'd0, lat);
        checks++;
        if (lat !== 1 || res_m !== 32'h09FF || dbz_m !== 1'b1) begin
            errors++;
            $display("FAIL div_9_0: lat=%0d result=%h dbz=%b, want 1 09ff 1", lat, res_m, dbz_m);
        end
        consume();
        checks++;
        if (dbz_m !== 1'b0 || ir_m !== 1'b1) begin
            errors++;
            $display("FAIL dbz_clear: dbz=%b in_ready=%b, want 0 1", dbz_m, ir_m);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        issue(1'b0, 2'b10, 16'd13, 16'd11, lat);
        checks++;
        if (lat !== 9 || res_m !== 32'h008F) begin
            errors++;
            $display("FAIL mul_13_11: lat=%0d result=%h, want 9 008f", lat, res_m);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid_t = 1'b1; op_t = 2'b00; a_t = 16'($urandom); b_t = 16'($urandom);
            @(posedge clk); #1;
            in_valid_t = 1'b0;
            checks++;
            if (ov_m !== 1'b1 || ir_m !== 1'b0 || res_m !== 32'h008F || dbz_m !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b result=%h, want 1 0 008f",
                         i, ov_m, ir_m, res_m);
            end
        end
        consume();
        checks++;
        if (ov_m !== 1'b0 || ir_m !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b, want 0 1", ov_m, ir_m);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        sel = 1'b0; op_t = 2'b11; a_t = 16'd200; b_t = 16'd7; in_valid_t = 1'b1;
        @(posedge clk); #1;
        in_valid_t = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1; out_ready_t = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready_t = 1'b0;
        checks++;
        if (ir_m !== 1'b1 || ov_m !== 1'b0 || res_m !== 32'd0 || dbz_m !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: in_ready=%b out_valid=%b result=%h dbz=%b, want 1 0 0 0",
                     ir_m, ov_m, res_m, dbz_m);
        end
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ov_m !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_output: out_valid high %0d cycles, want 0", seen);
        end
        issue(1'b0, 2'b00, 16'd1, 16'd1, lat);
        checks++;
        if (lat !== 1 || res_m !== 32'h0002) begin
            errors++;
            $display("FAIL add_after_abort: lat=%0d result=%h, want 1 0002", lat, res_m);
        end
        consume();
    endtask

    task automatic test_random(input bit s, input int w, input int n);
        logic [31:0] er;
        logic        ez;
        int          elat;
        int          lat;
        logic [1:0]  o;
        logic [15:0] x;
        logic [15:0] y;
        int          pick;
        for (int i = 0; i < n; i++) begin
            o = 2'($urandom_range(0, 3));
            x = 16'($urandom);
            y = 16'($urandom);
            pick = $urandom_range(0, 7);
            if (pick == 0) y = 16'd0;
            else if (pick == 1) x = 16'hFFFF;
            else if (pick == 2) y = x;
            else if (pick == 3) y = 16'd1;
            if (w == 8) begin
                x[15:8] = 8'h00;
                y[15:8] = 8'h00;
            end
            model(w, o, {16'h0000, x}, {16'h0000, y}, er, ez, elat);
            issue(s, o, x, y, lat);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            checks++;
            if (lat !== elat) begin
                errors++;
                $display("FAIL rand_w%0d_lat op=%0d a=%h b=%h: got %0d want %0d", w, o, x, y, lat, elat);
            end
            checks++;
            if (res_m !== er || dbz_m !== ez || ov_m !== 1'b1) begin
                errors++;
                $display("FAIL rand_w%0d_res op=%0d a=%h b=%h: got %h/%b valid=%b want %h/%b",
                         w, o, x, y, res_m, dbz_m, ov_m, er, ez);
            end
            consume();
            checks++;
            if (ir_m !== 1'b1 || ov_m !== 1'b0 || dbz_m !== 1'b0) begin
                errors++;
                $display("FAIL rand_w%0d_release: in_ready=%b out_valid=%b dbz=%b, want 1 0 0",
                         w, ir_m, ov_m, dbz_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_mul();
        test_div();
        test_backpressure();
        test_reset_abort();
        test_random(1'b0, 8, 150);
        test_random(1'b1, 16, 150);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal values 4..32.
REQ-002 clk  input  1  single clock for all logic; rising edge only.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  operand/opcode bundle present.
REQ-005 in_ready  output  1  block can accept a bundle this cycle.
REQ-006 op  input  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 a  input  WIDTH  first operand, unsigned.
REQ-008 b  input  WIDTH  second operand, unsigned.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  2*WIDTH  operation result; format per op.
REQ-012 div_by_zero  output  1  qualifies result; set only for a div with b==0.

Function
REQ-013 Accept when in_valid && in_ready; op, a and b are registered on that edge and ignored afterwards.
REQ-014 FSM states: IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE -> DONE on accept of add, sub, or div with b==0; out_valid rises 1 cycle after the accept edge.
REQ-016 IDLE -> CALC on accept of mul, or div with b!=0; CALC lasts exactly WIDTH cycles, one bit per cycle, then DONE; out_valid rises WIDTH+1 cycles after the accept edge.
REQ-017 DONE -> IDLE on out_valid && out_ready; in_ready rises the following cycle; no same-cycle accept/complete bypass.
REQ-018 In DONE with out_ready low, result and div_by_zero hold stable indefinitely.
REQ-019 add: result[WIDTH:0] = a+b, bit WIDTH = carry; upper bits zero.
REQ-020 sub: result[WIDTH-1:0] = (a-b) mod 2^WIDTH; result[WIDTH] = borrow (1 when a<b); upper bits zero.
REQ-021 mul: result = full 2*WIDTH-bit unsigned product; shift-add, one multiplier bit per CALC cycle.
REQ-022 div: restoring division, one quotient bit per CALC cycle; result[WIDTH-1:0] = quotient, result[2*WIDTH-1:WIDTH] = remainder.
REQ-023 div with b==0: quotient all-ones, remainder = a, div_by_zero = 1; no CALC cycles.
REQ-024 div_by_zero = 0 for every other result; cleared when the block leaves DONE.
REQ-025 in_valid during CALC or DONE has no effect; the operand registers do not change.
REQ-026 Unused result bits are driven to zero, never X.

Reset
REQ-027 rst high at a rising edge forces state=IDLE, out_valid=0, result=0, div_by_zero=0, in_ready=1 from the next cycle.
REQ-028 rst in CALC or DONE aborts the operation; the partial result is discarded and never presented.
REQ-029 rst dominates in_valid and out_ready in the same cycle; no accept and no completion occur.

Verification (WIDTH=8)
REQ-030 Scenario: add a=200 b=100 -> result=0x012C, out_valid 1 cycle after accept, div_by_zero=0.
REQ-031 Scenario: sub a=5 b=10 -> result=0x01FB (borrow=1); then mul a=255 b=255 -> result=0xFE01 exactly 9 cycles after accept.
REQ-032 Scenario: div a=200 b=7 -> result=0x041C (quotient 28, remainder 4) 9 cycles after accept; div a=9 b=0 -> result=0x09FF, div_by_zero=1, 1 cycle after accept.
REQ-033 Scenario: mul 13*11 with out_ready held low 5 cycles after out_valid -> result stays 0x008F, in_ready stays 0, in_valid pulses ignored; completes on the first out_ready cycle.
REQ-034 Scenario: rst asserted 3 cycles into a div -> next cycle in_ready=1, out_valid=0, result=0; a following add 1+1 returns 0x0002.
REQ-035 Scenario: randomized ops and operands against a reference model, at WIDTH=8 and WIDTH=16, with random out_ready backpressure; zero mismatches.
